oled_pattern_gen: RTL and testbench



---
 rtl/oled_pkg.sv | 42 ++++
 rtl/oled_pattern_gen_btn_debounce.sv | 44 ++++
 rtl/oled_pattern_gen.sv | 128 ++++++++++++
 tb/tb_oled_pattern_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared colour constants, pattern-mode encoding and default panel geometry
// for the OLED test-pattern generator.
package oled_pkg;

  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_BLACK   = 16'h0000;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_CYAN    = 16'h07FF;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;

  localparam int C_WIDTH_DEF         = 128;
  localparam int C_HEIGHT_DEF        = 160;
  localparam int C_BOX_DEF           = 16;
  localparam int C_DEBOUNCE_BITS_DEF = 16;

  typedef enum logic [1:0] {
    MODE_CHECKER  = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_BOX      = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  // Classic SMPTE-like ordering, brightest bar on the left.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_YELLOW;
      3'd2:    c = C_CYAN;
      3'd3:    c = C_GREEN;
      3'd4:    c = C_MAGENTA;
      3'd5:    c = C_RED;
      3'd6:    c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/oled_pattern_gen_btn_debounce.sv
// Button conditioner: two-flop synchroniser, saturating stability counter,
// and a one-clock pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int C_bits = 16
) (
  input  logic clki,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic              s1, s2, s3;
  logic [C_bits-1:0] cnt;
  logic              stable;
  logic              settled;

  // Only latch once the level has held for the full count and is not changing now.
  assign settled = (s2 == s3) && (&cnt);

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      s3   <= s2;
      rise <= 1'b0;
      if (s2 != s3)
        cnt <= '0;
      else if (!(&cnt))
        cnt <= cnt + {{(C_bits-1){1'b0}}, 1'b1};
      if (settled) begin
        stable <= s2;
        rise   <= s2 & ~stable;
      end
    end
  end

endmodule

// File: rtl/oled_pattern_gen.sv
// Zero-latency RGB565 test-pattern source for the OLED driver; animation
// state advances once per detected frame start.
module oled_pattern_gen
  import oled_pkg::*;
#(
  parameter int C_width         = C_WIDTH_DEF,
  parameter int C_height        = C_HEIGHT_DEF,
  parameter int C_box           = C_BOX_DEF,
  parameter int C_debounce_bits = C_DEBOUNCE_BITS_DEF
) (
  input  logic        clki,
  input  logic        rst,
  input  logic [6:0]  x,
  input  logic [7:0]  y,
  input  logic        btn,
  output logic [15:0] color,
  output logic        frame_tick,
  output logic [1:0]  mode
);

  localparam logic [6:0] PX_RST = 7'(C_width - 1);
  localparam logic [7:0] PY_RST = 8'(C_height - 1);
  localparam logic [6:0] BX_MAX = 7'(C_width - C_box);
  localparam logic [7:0] BY_MAX = 8'(C_height - C_box);
  localparam logic [8:0] BOX9   = 9'(C_box);

  logic [6:0] px;
  logic [7:0] py;
  logic [7:0] fcnt;
  logic [6:0] bx;
  logic [7:0] by;
  logic       dx_neg, dy_neg;
  mode_e      mode_q;
  logic       mode_pending;
  logic       press;

  btn_debounce #(.C_bits(C_debounce_bits)) u_btn (
    .clki (clki),
    .rst  (rst),
    .btn  (btn),
    .rise (press)
  );

  // Previous coordinate resets to the last pixel so the first (0,0) is a frame start.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      px         <= PX_RST;
      py         <= PY_RST;
      frame_tick <= 1'b0;
    end else begin
      px         <= x;
      py         <= y;
      frame_tick <= (x == 7'd0) && (y == 8'd0) && !((px == 7'd0) && (py == 8'd0));
    end
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      fcnt         <= 8'd0;
      bx           <= 7'd0;
      by           <= 8'd0;
      dx_neg       <= 1'b0;
      dy_neg       <= 1'b0;
      mode_q       <= MODE_CHECKER;
      mode_pending <= 1'b0;
    end else begin
      mode_pending <= press | (mode_pending & ~frame_tick);
      if (frame_tick) begin
        fcnt <= fcnt + 8'd1;
        if (mode_pending)
          mode_q <= mode_e'(mode_q + 2'd1);

        if (dx_neg) begin
          if (bx == 7'd0) begin
            dx_neg <= 1'b0;
            bx     <= 7'd1;
          end else begin
            bx <= bx - 7'd1;
          end
        end else if (bx >= BX_MAX) begin
          dx_neg <= 1'b1;
          bx     <= bx - 7'd1;
        end else begin
          bx <= bx + 7'd1;
        end

        if (dy_neg) begin
          if (by == 8'd0) begin
            dy_neg <= 1'b0;
            by     <= 8'd1;
          end else begin
            by <= by - 8'd1;
          end
        end else if (by >= BY_MAX) begin
          dy_neg <= 1'b1;
          by     <= by - 8'd1;
        end else begin
          by <= by + 8'd1;
        end
      end
    end
  end

  assign mode = mode_q;

  logic [7:0] ysum;
  logic [8:0] x9, y9, bx9, by9;
  logic       in_box;

  assign ysum   = y + fcnt;
  assign x9     = {2'b00, x};
  assign y9     = {1'b0, y};
  assign bx9    = {2'b00, bx};
  assign by9    = {1'b0, by};
  assign in_box = (x9 >= bx9) && (x9 < bx9 + BOX9) && (y9 >= by9) && (y9 < by9 + BOX9);

  always_comb begin
    color = C_BLACK;
    case (mode_q)
      MODE_CHECKER:  color = (x[3] ^ ysum[3]) ? C_GREEN : C_RED;
      MODE_BARS:     color = bar_color(x[6:4]);
      MODE_BOX:      color = in_box ? C_WHITE : C_BLUE;
      MODE_GRADIENT: color = {x[6:2], y[7:2], fcnt[7:3]};
      default:       color = C_BLACK;
    endcase
  end

endmodule

// File: tb/tb_oled_pattern_gen.sv
// Directed bench for oled_pattern_gen: frame detect, pattern colours, button
// debounce/mode stepping, box bounce and asynchronous reset.
module tb_oled_pattern_gen;

  localparam int DB   = 4;
  localparam int HOLD = (1 << DB) + 8;

  logic        clki = 1'b0;
  logic        rst;
  logic [6:0]  x;
  logic [7:0]  y;
  logic        btn;
  logic [15:0] color;
  logic        frame_tick;
  logic [1:0]  mode;

  int checks = 0;
  int errors = 0;
  int nframes = 0;
  int ticks;
  int first_tick;

  oled_pattern_gen #(
    .C_width(128), .C_height(160), .C_box(16), .C_debounce_bits(DB)
  ) dut (
    .clki(clki), .rst(rst), .x(x), .y(y), .btn(btn),
    .color(color), .frame_tick(frame_tick), .mode(mode)
  );

  always #5 clki = ~clki;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [6:0] xi, input logic [7:0] yi);
    x = xi;
    y = yi;
    @(posedge clki);
    #1;
  endtask

  // Colour is combinational: probe it between edges so the probe point never gets clocked.
  task automatic check_pix(input string tag, input logic [6:0] xi, input logic [7:0] yi,
                           input logic [15:0] exp);
    @(posedge clki);
    #1;
    x = xi;
    y = yi;
    #2;
    chk(tag, 32'(color), 32'(exp));
    x = 7'd1;
    y = 8'd1;
  endtask

  task automatic do_frame();
    step(7'd1, 8'd0);
    step(7'd0, 8'd0);
    step(7'd1, 8'd1);
    nframes++;
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (HOLD) step(7'd5, 8'd5);
    btn = 1'b0;
    repeat (HOLD) step(7'd5, 8'd5);
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    x   = 7'd1;
    y   = 8'd1;
    repeat (3) @(posedge clki);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    check_pix("chk_0_0", 7'd0, 8'd0, 16'hF800);
    check_pix("chk_8_0", 7'd8, 8'd0, 16'h07E0);

    ticks = 0;
    first_tick = -1;
    for (int yy = 0; yy < 160; yy++) begin
      for (int xx = 0; xx < 128; xx++) begin
        step(7'(xx), 8'(yy));
        if (frame_tick) begin
          ticks++;
          if (first_tick < 0) first_tick = yy * 128 + xx;
        end
      end
    end
    nframes = 1;
    chk("sweep_ticks", 32'(ticks), 32'd1);
    chk("sweep_tick_pos", 32'(first_tick), 32'd0);
    chk("sweep_mode", 32'(mode), 32'd0);

    do_frame();
    do_frame();
    check_pix("scroll_0_5", 7'd0, 8'd5, 16'h07E0);
    check_pix("scroll_8_5", 7'd8, 8'd5, 16'hF800);

    step(7'd1, 8'd0);
    ticks = 0;
    repeat (10) begin
      step(7'd0, 8'd0);
      if (frame_tick) ticks++;
    end
    step(7'd1, 8'd1);
    nframes++;
    chk("hold_origin_ticks", 32'(ticks), 32'd1);
    check_pix("scroll4_0_3", 7'd0, 8'd3, 16'hF800);
    check_pix("scroll4_0_4", 7'd0, 8'd4, 16'h07E0);

    press();
    chk("pending_mode", 32'(mode), 32'd0);
    step(7'd1, 8'd0);
    step(7'd0, 8'd0);
    chk("press_tick", 32'(frame_tick), 32'd1);
    chk("mode_at_tick", 32'(mode), 32'd0);
    step(7'd1, 8'd1);
    nframes++;
    chk("mode_after_tick", 32'(mode), 32'd1);
    check_pix("bar_yellow", 7'd20, 8'd0, 16'hFFE0);
    check_pix("bar_white", 7'd0, 8'd0, 16'hFFFF);
    check_pix("bar_blue", 7'd100, 8'd3, 16'h001F);
    check_pix("bar_black", 7'd127, 8'd0, 16'h0000);

    btn = 1'b1;
    repeat (6) step(7'd5, 8'd5);
    btn = 1'b0;
    repeat (HOLD) step(7'd5, 8'd5);
    do_frame();
    chk("glitch_mode", 32'(mode), 32'd1);

    press();
    press();
    do_frame();
    chk("two_press_mode", 32'(mode), 32'd2);
    do_frame();
    chk("pending_cleared", 32'(mode), 32'd2);

    // nframes == 8 -> box at (8,8)
    check_pix("box8_in_tl", 7'd8, 8'd8, 16'hFFFF);
    check_pix("box8_in_br", 7'd23, 8'd23, 16'hFFFF);
    check_pix("box8_out_r", 7'd24, 8'd8, 16'h001F);
    check_pix("box8_out_l", 7'd7, 8'd8, 16'h001F);
    check_pix("box8_out_b", 7'd8, 8'd24, 16'h001F);

    while (nframes < 112) do_frame();
    check_pix("box112_in", 7'd112, 8'd112, 16'hFFFF);
    check_pix("box112_out", 7'd111, 8'd112, 16'h001F);
    check_pix("box112_edge", 7'd127, 8'd127, 16'hFFFF);
    check_pix("box112_out_b", 7'd112, 8'd128, 16'h001F);

    do_frame();
    check_pix("box113_in", 7'd111, 8'd113, 16'hFFFF);
    check_pix("box113_out_l", 7'd110, 8'd113, 16'h001F);
    check_pix("box113_in_br", 7'd126, 8'd128, 16'hFFFF);
    check_pix("box113_out_r", 7'd127, 8'd113, 16'h001F);

    while (nframes < 145) do_frame();
    check_pix("box145_in", 7'd79, 8'd143, 16'hFFFF);
    check_pix("box145_out_t", 7'd79, 8'd142, 16'h001F);
    check_pix("box145_in_br", 7'd94, 8'd158, 16'hFFFF);
    check_pix("box145_out_r", 7'd95, 8'd143, 16'h001F);

    press();
    do_frame();
    chk("mode_grad", 32'(mode), 32'd3);
    check_pix("gradient", 7'd100, 8'd200, 16'hCE52);

    press();
    do_frame();
    chk("mode_wrap", 32'(mode), 32'd0);
    press();
    do_frame();
    press();
    do_frame();
    chk("mode_box_again", 32'(mode), 32'd2);
    check_pix("box149_out", 7'd50, 8'd70, 16'h001F);
    check_pix("box149_in", 7'd75, 8'd139, 16'hFFFF);

    repeat (2) step(7'd50, 8'd70);
    step(7'd1, 8'd0);
    step(7'd0, 8'd0);
    chk("pre_rst_tick", 32'(frame_tick), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_tick", 32'(frame_tick), 32'd0);
    chk("async_rst_mode", 32'(mode), 32'd0);
    check_pix("rst_fcnt_zero", 7'd0, 8'd5, 16'hF800);
    rst = 1'b0;

    ticks = 0;
    repeat (5) begin
      step(7'd0, 8'd0);
      if (frame_tick) ticks++;
    end
    step(7'd1, 8'd1);
    chk("post_rst_ticks", 32'(ticks), 32'd1);
    chk("post_rst_mode", 32'(mode), 32'd0);
    check_pix("post_rst_0_7", 7'd0, 8'd7, 16'h07E0);
    check_pix("post_rst_0_6", 7'd0, 8'd6, 16'hF800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
